cache_ctrl_counters: RTL and testbench



---
 rtl/cache_ctrl_counters.sv | 122 ++++++++++++
 tb/tb_cache_ctrl_counters.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_counters.sv
// Datapath helpers for the RAID5 cache controller: an 11-bit block-number
// counter, an 8-bit programmable cache word counter with rollover and
// half-way flags, and a six-way 32-bit selector for cache write data.

// Generic rollover counter. It counts 1..rollover_val and then wraps to 1.
// The rollover flag is registered and tracks whether the count just written
// equals the terminal value.
module cache_ctrl_rollover_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] next_count;
  logic             next_flag;

  // Next count for an enabled cycle. A zero terminal value parks the counter
  // at zero. A count at or above the terminal value wraps to 1, which also
  // covers the terminal value being lowered while the count is in flight.
  always_comb begin
    next_count = count_out;
    next_flag  = rollover_flag;
    if (rollover_val == '0) begin
      next_count = '0;
      next_flag  = 1'b0;
    end else if (count_out < rollover_val) begin
      next_count = count_out + 1'b1;
      next_flag  = (next_count == rollover_val);
    end else begin
      next_count = {{(WIDTH-1){1'b0}}, 1'b1};
      next_flag  = (next_count == rollover_val);
    end
  end

  // Count and flag registers. Clear wins over enable. With neither asserted,
  // both hold, so the flag is not re-evaluated when the terminal value moves.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (clear) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else if (count_enable) begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule

module cache_ctrl_counters (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        blk_cnt_enable,
  input  logic        blk_clear,
  output logic [10:0] blk_count_out,
  output logic        blk_rollover_flag,
  input  logic        cache_cnt_enable,
  input  logic        cache_clear,
  input  logic [7:0]  cache_rollover_val,
  output logic [7:0]  cache_count_out,
  output logic        cache_rollover_flag,
  output logic        cache_dump_half,
  input  logic [31:0] ahb_data,
  input  logic [31:0] sram1_data,
  input  logic [31:0] sram2_data,
  input  logic [31:0] sd1_data,
  input  logic [31:0] sd2_data,
  input  logic [31:0] sd3_data,
  input  logic [2:0]  select_out,
  output logic [31:0] output_data
);

  localparam logic [10:0] BLK_ROLLOVER_VAL = 11'd2047;

  cache_ctrl_rollover_counter #(.WIDTH(11)) u_blk_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (blk_clear),
    .count_enable  (blk_cnt_enable),
    .rollover_val  (BLK_ROLLOVER_VAL),
    .count_out     (blk_count_out),
    .rollover_flag (blk_rollover_flag)
  );

  cache_ctrl_rollover_counter #(.WIDTH(8)) u_cache_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cache_clear),
    .count_enable  (cache_cnt_enable),
    .rollover_val  (cache_rollover_val),
    .count_out     (cache_count_out),
    .rollover_flag (cache_rollover_flag)
  );

  // Half-way flag uses the live terminal value so the cache dump logic sees
  // a change of rollover value immediately; a zero count never reports half.
  assign cache_dump_half = (cache_count_out != 8'd0) &&
                           (cache_count_out >= (cache_rollover_val >> 1));

  // Cache write-data selector; unused codes drive zeros.
  always_comb begin
    output_data = 32'h0;
    case (select_out)
      3'd0:    output_data = ahb_data;
      3'd1:    output_data = sram1_data;
      3'd2:    output_data = sram2_data;
      3'd3:    output_data = sd1_data;
      3'd4:    output_data = sd2_data;
      3'd5:    output_data = sd3_data;
      default: output_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_counters.sv
module tb_cache_ctrl_counters;

  logic        clk;
  logic        n_rst;
  logic        blk_cnt_enable;
  logic        blk_clear;
  logic [10:0] blk_count_out;
  logic        blk_rollover_flag;
  logic        cache_cnt_enable;
  logic        cache_clear;
  logic [7:0]  cache_rollover_val;
  logic [7:0]  cache_count_out;
  logic        cache_rollover_flag;
  logic        cache_dump_half;
  logic [31:0] ahb_data, sram1_data, sram2_data, sd1_data, sd2_data, sd3_data;
  logic [2:0]  select_out;
  logic [31:0] output_data;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_cache_cnt;
  bit m_cache_flag;
  int m_blk_cnt;
  bit m_blk_flag;

  cache_ctrl_counters dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .blk_cnt_enable      (blk_cnt_enable),
    .blk_clear           (blk_clear),
    .blk_count_out       (blk_count_out),
    .blk_rollover_flag   (blk_rollover_flag),
    .cache_cnt_enable    (cache_cnt_enable),
    .cache_clear         (cache_clear),
    .cache_rollover_val  (cache_rollover_val),
    .cache_count_out     (cache_count_out),
    .cache_rollover_flag (cache_rollover_flag),
    .cache_dump_half     (cache_dump_half),
    .ahb_data            (ahb_data),
    .sram1_data          (sram1_data),
    .sram2_data          (sram2_data),
    .sd1_data            (sd1_data),
    .sd2_data            (sd2_data),
    .sd3_data            (sd3_data),
    .select_out          (select_out),
    .output_data         (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_half(int cnt, int n);
    return (cnt != 0) && (cnt >= n / 2);
  endfunction

  function automatic logic [31:0] model_mux(int sel);
    logic [31:0] src [6];
    src = '{ahb_data, sram1_data, sram2_data, sd1_data, sd2_data, sd3_data};
    return (sel < 6) ? src[sel] : 32'h0;
  endfunction

  task automatic model_reset();
    m_cache_cnt = 0; m_cache_flag = 0; m_blk_cnt = 0; m_blk_flag = 0;
  endtask

  // Counting rule from the block description: count 1..N, wrap to 1,
  // clear to 0, N == 0 keeps the counter at 0.
  task automatic model_count(inout int cnt, inout bit flag, input bit en,
                             input bit clr, input int n);
    if (clr) begin
      cnt = 0; flag = 0;
    end else if (en) begin
      if (n == 0) cnt = 0;
      else cnt = (cnt >= n) ? 1 : cnt + 1;
      flag = (n != 0) && (cnt == n);
    end
  endtask

  // Drive controls (at a falling edge), take one rising edge, update the
  // model and return on the next falling edge where outputs are stable.
  task automatic step(input bit ce, input bit cc, input bit be, input bit bc);
    cache_cnt_enable = ce; cache_clear = cc;
    blk_cnt_enable = be; blk_clear = bc;
    @(posedge clk);
    model_count(m_cache_cnt, m_cache_flag, ce, cc, int'(cache_rollover_val));
    model_count(m_blk_cnt, m_blk_flag, be, bc, 2047);
    @(negedge clk);
    cache_cnt_enable = 0; cache_clear = 0;
    blk_cnt_enable = 0; blk_clear = 0;
  endtask

  task automatic test_reset();
    n_rst = 0;
    cache_cnt_enable = 0; cache_clear = 0; blk_cnt_enable = 0; blk_clear = 0;
    cache_rollover_val = 8'd255;
    ahb_data = 32'hA5A5_0001; sram1_data = 0; sram2_data = 0;
    sd1_data = 0; sd2_data = 0; sd3_data = 0; select_out = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (cache_count_out !== 8'd0 || cache_rollover_flag !== 1'b0 || cache_dump_half !== 1'b0) begin
      bad++; $display("FAIL reset_cache: cnt=%0d flag=%b half=%b required 0 0 0",
                      cache_count_out, cache_rollover_flag, cache_dump_half);
    end
    total++;
    if (blk_count_out !== 11'd0 || blk_rollover_flag !== 1'b0) begin
      bad++; $display("FAIL reset_blk: cnt=%0d flag=%b required 0 0", blk_count_out, blk_rollover_flag);
    end
    total++;
    if (output_data !== 32'hA5A5_0001) begin
      bad++; $display("FAIL reset_mux: got %h required a5a50001", output_data);
    end
    n_rst = 1;
    @(negedge clk);
  endtask

  task automatic test_cache_full_wrap();
    int first_half;
    first_half = -1;
    cache_rollover_val = 8'd255;
    step(0, 1, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      int exp_cnt;
      step(1, 0, 0, 0);
      exp_cnt = (i <= 255) ? i : 1;
      total++;
      if (cache_count_out !== exp_cnt[7:0] || cache_rollover_flag !== (exp_cnt == 255) ||
          cache_dump_half !== model_half(exp_cnt, 255)) begin
        bad++; $display("FAIL wrap255 step %0d: cnt=%0d flag=%b half=%b required %0d %b %b",
                        i, cache_count_out, cache_rollover_flag, cache_dump_half,
                        exp_cnt, exp_cnt == 255, model_half(exp_cnt, 255));
      end
      if (cache_dump_half === 1'b1 && first_half < 0) first_half = int'(cache_count_out);
    end
    total++;
    if (first_half != 127) begin
      bad++; $display("FAIL half_first: first high at %0d required 127", first_half);
    end
  endtask

  task automatic test_clear_priority();
    cache_rollover_val = 8'd10;
    step(0, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    total++;
    if (cache_count_out !== 8'd6) begin
      bad++; $display("FAIL clr_pre: cnt=%0d required 6", cache_count_out);
    end
    step(1, 1, 0, 0);
    total++;
    if (cache_count_out !== 8'd0 || cache_rollover_flag !== 1'b0) begin
      bad++; $display("FAIL clr_prio: cnt=%0d flag=%b required 0 0", cache_count_out, cache_rollover_flag);
    end
    for (int i = 1; i <= 12; i++) begin
      int exp_cnt;
      step(1, 0, 0, 0);
      exp_cnt = (i <= 10) ? i : i - 10;
      total++;
      if (cache_count_out !== exp_cnt[7:0] || cache_rollover_flag !== (exp_cnt == 10)) begin
        bad++; $display("FAIL clr_resume %0d: cnt=%0d flag=%b required %0d %b",
                        i, cache_count_out, cache_rollover_flag, exp_cnt, exp_cnt == 10);
      end
    end
  endtask

  task automatic test_lowered_and_zero();
    cache_rollover_val = 8'd255;
    step(0, 1, 0, 0);
    repeat (200) step(1, 0, 0, 0);
    total++;
    if (cache_count_out !== 8'd200) begin
      bad++; $display("FAIL lower_pre: cnt=%0d required 200", cache_count_out);
    end
    cache_rollover_val = 8'd50;
    #1;
    total++;
    if (cache_dump_half !== 1'b1) begin
      bad++; $display("FAIL lower_half: half=%b required 1", cache_dump_half);
    end
    @(negedge clk);
    step(1, 0, 0, 0);
    total++;
    if (cache_count_out !== 8'd1 || cache_rollover_flag !== 1'b0) begin
      bad++; $display("FAIL lower_wrap: cnt=%0d flag=%b required 1 0", cache_count_out, cache_rollover_flag);
    end
    step(0, 1, 0, 0);
    cache_rollover_val = 8'd0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      total++;
      if (cache_count_out !== 8'd0 || cache_rollover_flag !== 1'b0 || cache_dump_half !== 1'b0) begin
        bad++; $display("FAIL zero_val %0d: cnt=%0d flag=%b half=%b required 0 0 0",
                        i, cache_count_out, cache_rollover_flag, cache_dump_half);
      end
    end
  endtask

  task automatic test_blk_wrap();
    int flag_errs;
    flag_errs = 0;
    step(0, 0, 0, 1);
    for (int i = 1; i <= 2047; i++) begin
      step(0, 0, 1, 0);
      if (blk_count_out !== i[10:0] || blk_rollover_flag !== (i == 2047)) flag_errs++;
    end
    total++;
    if (flag_errs != 0) begin
      bad++; $display("FAIL blk_ramp: %0d cycles wrong, required 0", flag_errs);
    end
    total++;
    if (blk_count_out !== 11'd2047 || blk_rollover_flag !== 1'b1) begin
      bad++; $display("FAIL blk_top: cnt=%0d flag=%b required 2047 1", blk_count_out, blk_rollover_flag);
    end
    step(0, 0, 1, 0);
    total++;
    if (blk_count_out !== 11'd1 || blk_rollover_flag !== 1'b0) begin
      bad++; $display("FAIL blk_wrap: cnt=%0d flag=%b required 1 0", blk_count_out, blk_rollover_flag);
    end
    step(0, 0, 0, 1);
    total++;
    if (blk_count_out !== 11'd0 || blk_rollover_flag !== 1'b0) begin
      bad++; $display("FAIL blk_clear: cnt=%0d flag=%b required 0 0", blk_count_out, blk_rollover_flag);
    end
  endtask

  task automatic test_mux();
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h0, 32'h1, 32'h2, 32'h66666666, 32'hFFFFFFFF, 32'h99999999, 32'h0, 32'h0};
    ahb_data = 32'h0; sram1_data = 32'h1; sram2_data = 32'h2;
    sd1_data = 32'h66666666; sd2_data = 32'hFFFFFFFF; sd3_data = 32'h99999999;
    for (int s = 0; s < 8; s++) begin
      select_out = s[2:0];
      #1;
      total++;
      if (output_data !== exp_tab[s]) begin
        bad++; $display("FAIL mux_sel%0d: got %h required %h", s, output_data, exp_tab[s]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    cache_rollover_val = 8'd100;
    step(0, 1, 0, 1);
    for (int i = 1; i <= 37; i++) step(1, 0, i <= 5, 0);
    total++;
    if (cache_count_out !== 8'd37 || blk_count_out !== 11'd5) begin
      bad++; $display("FAIL areset_pre: cache=%0d blk=%0d required 37 5", cache_count_out, blk_count_out);
    end
    #2 n_rst = 0;
    #1;
    model_reset();
    total++;
    if (cache_count_out !== 8'd0 || blk_count_out !== 11'd0 || cache_rollover_flag !== 1'b0 ||
        blk_rollover_flag !== 1'b0 || cache_dump_half !== 1'b0) begin
      bad++; $display("FAIL areset_now: cache=%0d blk=%0d flags=%b%b%b required 0 0 000",
                      cache_count_out, blk_count_out, cache_rollover_flag, blk_rollover_flag, cache_dump_half);
    end
    cache_cnt_enable = 1; blk_cnt_enable = 1;
    @(negedge clk);
    total++;
    if (cache_count_out !== 8'd0 || blk_count_out !== 11'd0) begin
      bad++; $display("FAIL areset_hold: cache=%0d blk=%0d required 0 0", cache_count_out, blk_count_out);
    end
    n_rst = 1;
    step(1, 0, 1, 0);
    total++;
    if (cache_count_out !== 8'd1 || blk_count_out !== 11'd1) begin
      bad++; $display("FAIL areset_restart: cache=%0d blk=%0d required 1 1", cache_count_out, blk_count_out);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    cache_rollover_val = 8'd20;
    step(0, 1, 0, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) cache_rollover_val = 8'($urandom_range(1, 40));
      ahb_data = $urandom; sram1_data = $urandom; sram2_data = $urandom;
      sd1_data = $urandom; sd2_data = $urandom; sd3_data = $urandom;
      select_out = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
      total++;
      if (int'(cache_count_out) != m_cache_cnt || cache_rollover_flag !== m_cache_flag ||
          cache_dump_half !== model_half(m_cache_cnt, int'(cache_rollover_val)) ||
          int'(blk_count_out) != m_blk_cnt || blk_rollover_flag !== m_blk_flag ||
          output_data !== model_mux(int'(select_out))) begin
        bad++; errs++;
        if (errs <= 5)
          $display("FAIL random %0d: cache=%0d/%b/%b blk=%0d/%b mux=%h required %0d/%b/%b %0d/%b %h",
                   i, cache_count_out, cache_rollover_flag, cache_dump_half, blk_count_out,
                   blk_rollover_flag, output_data, m_cache_cnt, m_cache_flag,
                   model_half(m_cache_cnt, int'(cache_rollover_val)), m_blk_cnt, m_blk_flag,
                   model_mux(int'(select_out)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cache_full_wrap();
    test_clear_priority();
    test_lowered_and_zero();
    test_blk_wrap();
    test_mux();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
